// File: rtl/elite_spi_rx.sv
// SPI mode-0 slave receiver feeding the 7-segment display word.
// It echoes the previously received byte on MISO and flags frames that end mid-byte.
module elite_spi_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 8
) (
   input  logic              CLOCK_50,
   input  logic              Reset_SPI_Rx,
   input  logic              SPI_SCLK,
   input  logic              SPI_CS_n,
   input  logic              SPI_MOSI,
   output logic              SPI_MISO,
   output logic [DATA_W-1:0] Elite_7Seg_Disp_Word,
   output logic              Elite_7Seg_Set_Flag,
   output logic              SPI_Frame_Err,
   output logic [7:0]        SPI_Byte_Count
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      ARMWAIT,
      IDLE,
      ACTIVE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_d;
   logic                   cs_d;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   cs_rise;
   logic                   cs_fall;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-2:0]      rx_sr;
   logic [DATA_W-1:0]      tx_sr;
   logic                   reload_pending;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   assign SPI_MISO  = (state == ACTIVE) ? tx_sr[DATA_W-1] : 1'b1;

   // The CS_n chain clears low so ARMWAIT waits for a genuinely observed high level.
   always_ff @(posedge CLOCK_50) begin
      if (Reset_SPI_Rx) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset_SPI_Rx) begin
         state                <= ARMWAIT;
         bit_cnt              <= '0;
         rx_sr                <= '0;
         tx_sr                <= '1;
         reload_pending       <= 1'b0;
         Elite_7Seg_Disp_Word <= '0;
         Elite_7Seg_Set_Flag  <= 1'b0;
         SPI_Frame_Err        <= 1'b0;
         SPI_Byte_Count       <= '0;
      end else begin
         Elite_7Seg_Set_Flag <= 1'b0;
         SPI_Frame_Err       <= 1'b0;
         case (state)
            ARMWAIT: begin
               if (cs_s)
                  state <= IDLE;
            end
            IDLE: begin
               if (cs_fall) begin
                  state          <= ACTIVE;
                  bit_cnt        <= '0;
                  tx_sr          <= Elite_7Seg_Disp_Word;
                  reload_pending <= 1'b0;
               end
            end
            ACTIVE: begin
               // Deselect takes precedence over any SCLK edge seen in the same cycle.
               if (cs_rise) begin
                  state          <= IDLE;
                  bit_cnt        <= '0;
                  reload_pending <= 1'b0;
                  if (bit_cnt != '0)
                     SPI_Frame_Err <= 1'b1;
               end else if (sclk_rise) begin
                  rx_sr <= {rx_sr[DATA_W-3:0], mosi_s};
                  if (bit_cnt == CNT_W'(DATA_W-1)) begin
                     Elite_7Seg_Disp_Word <= {rx_sr, mosi_s};
                     Elite_7Seg_Set_Flag  <= 1'b1;
                     SPI_Byte_Count       <= SPI_Byte_Count + 8'd1;
                     bit_cnt              <= '0;
                     reload_pending       <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (reload_pending) begin
                     tx_sr          <= Elite_7Seg_Disp_Word;
                     reload_pending <= 1'b0;
                  end else begin
                     tx_sr <= {tx_sr[DATA_W-2:0], 1'b1};
                  end
               end
            end
            default: state <= ARMWAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_elite_spi_rx.sv
// Self-checking bench for elite_spi_rx: an SPI master model drives bytes and a
// scoreboard matches every display strobe against the byte and count queued at drive time.
module tb_elite_spi_rx;

   localparam int HALF = 4;

   logic       CLOCK_50 = 1'b0;
   logic       Reset_SPI_Rx;
   logic       SPI_SCLK;
   logic       SPI_CS_n;
   logic       SPI_MOSI;
   logic       SPI_MISO;
   logic [7:0] Elite_7Seg_Disp_Word;
   logic       Elite_7Seg_Set_Flag;
   logic       SPI_Frame_Err;
   logic [7:0] SPI_Byte_Count;

   always #10 CLOCK_50 = ~CLOCK_50;

   elite_spi_rx #(
      .SYNC_STAGES(2),
      .DATA_W     (8)
   ) dut (
      .CLOCK_50            (CLOCK_50),
      .Reset_SPI_Rx        (Reset_SPI_Rx),
      .SPI_SCLK            (SPI_SCLK),
      .SPI_CS_n            (SPI_CS_n),
      .SPI_MOSI            (SPI_MOSI),
      .SPI_MISO            (SPI_MISO),
      .Elite_7Seg_Disp_Word(Elite_7Seg_Disp_Word),
      .Elite_7Seg_Set_Flag (Elite_7Seg_Set_Flag),
      .SPI_Frame_Err       (SPI_Frame_Err),
      .SPI_Byte_Count      (SPI_Byte_Count)
   );

   typedef struct {
      logic [7:0] data;
      logic [7:0] count;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         n_checks   = 0;
   int         n_errors   = 0;
   int         strobes    = 0;
   int         frame_errs = 0;
   logic [7:0] exp_count  = '0;
   logic [7:0] last_byte  = '0;
   logic [7:0] miso_b;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // Mode-0 master: MOSI set and MISO sampled during SCLK low, just before the rising edge.
   task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx_b);
      rx_b = '0;
      for (int i = 0; i < nbits; i++) begin
         SPI_MOSI = b[7-i];
         wait_clk(HALF);
         rx_b[7-i] = SPI_MISO;
         if (i == 7) begin
            exp_t e;
            exp_count = exp_count + 8'd1;
            e.data    = b;
            e.count   = exp_count;
            sb_q.push_back(e);
         end
         SPI_SCLK = 1'b1;
         wait_clk(HALF);
         SPI_SCLK = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input string tag);
      spi_bits(b, 8, miso_b);
      check_val(tag, {24'd0, miso_b}, {24'd0, last_byte});
      last_byte = b;
   endtask

   task automatic cs_low();
      SPI_CS_n = 1'b0;
      wait_clk(6);
   endtask

   task automatic cs_high();
      wait_clk(6);
      SPI_CS_n = 1'b1;
      wait_clk(10);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_word"}, {24'd0, Elite_7Seg_Disp_Word}, 32'h00);
      check_val({tag, "_flag"}, {31'd0, Elite_7Seg_Set_Flag}, 32'h0);
      check_val({tag, "_err"},  {31'd0, SPI_Frame_Err}, 32'h0);
      check_val({tag, "_count"}, {24'd0, SPI_Byte_Count}, 32'h00);
      check_val({tag, "_miso"}, {31'd0, SPI_MISO}, 32'h1);
   endtask

   always @(negedge CLOCK_50) begin
      if (!Reset_SPI_Rx) begin
         if (Elite_7Seg_Set_Flag) begin
            strobes++;
            check_val("strobe_expected", {31'd0, sb_q.size() != 0}, 32'h1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check_val("disp_word", {24'd0, Elite_7Seg_Disp_Word}, {24'd0, mon_e.data});
               check_val("byte_count", {24'd0, SPI_Byte_Count}, {24'd0, mon_e.count});
            end
         end
         if (SPI_Frame_Err)
            frame_errs++;
      end
   end

   initial begin
      SPI_SCLK     = 1'b0;
      SPI_CS_n     = 1'b1;
      SPI_MOSI     = 1'b0;
      Reset_SPI_Rx = 1'b1;
      wait_clk(4);
      check_reset_outputs("reset");
      Reset_SPI_Rx = 1'b0;
      wait_clk(10);

      // single byte; echo of the reset word is 0x00
      cs_low();
      send_byte(8'hA5, "single_miso");
      cs_high();
      check_val("single_strobes", strobes, 1);
      check_val("single_word", {24'd0, Elite_7Seg_Disp_Word}, 32'hA5);
      check_val("single_count", {24'd0, SPI_Byte_Count}, 32'h01);

      // echo burst
      cs_low();
      send_byte(8'h3C, "echo1_miso");
      cs_high();
      cs_low();
      send_byte(8'h5A, "echo2_miso");
      send_byte(8'hFF, "echo3_miso");
      cs_high();
      check_val("echo_strobes", strobes, 4);
      check_val("echo_word", {24'd0, Elite_7Seg_Disp_Word}, 32'hFF);
      check_val("echo_count", {24'd0, SPI_Byte_Count}, 32'h04);
      check_val("echo_frame_err", frame_errs, 0);

      // aborted frame after 5 bits
      cs_low();
      send_byte(8'h12, "abort1_miso");
      spi_bits(8'hE7, 5, miso_b);
      cs_high();
      check_val("abort_frame_err", frame_errs, 1);
      check_val("abort_word", {24'd0, Elite_7Seg_Disp_Word}, 32'h12);
      check_val("abort_strobes", strobes, 5);
      cs_low();
      send_byte(8'h81, "abort2_miso");
      cs_high();
      check_val("after_abort_word", {24'd0, Elite_7Seg_Disp_Word}, 32'h81);
      check_val("after_abort_strobes", strobes, 6);

      // CS rise coincides with the 8th SCLK rise
      cs_low();
      spi_bits(8'h96, 7, miso_b);
      SPI_MOSI = 1'b0;
      wait_clk(HALF);
      SPI_SCLK = 1'b1;
      SPI_CS_n = 1'b1;
      wait_clk(HALF);
      SPI_SCLK = 1'b0;
      wait_clk(10);
      check_val("prio_frame_err", frame_errs, 2);
      check_val("prio_strobes", strobes, 6);
      check_val("prio_word", {24'd0, Elite_7Seg_Disp_Word}, 32'h81);

      // reset after 4 bits with CS held low
      cs_low();
      spi_bits(8'hC3, 4, miso_b);
      Reset_SPI_Rx = 1'b1;
      wait_clk(2);
      check_reset_outputs("midreset");
      Reset_SPI_Rx = 1'b0;
      exp_count = '0;
      last_byte = '0;
      sb_q.delete();
      spi_bits(8'h3C, 4, miso_b);
      wait_clk(10);
      check_val("armwait_strobes", strobes, 6);
      check_val("armwait_count", {24'd0, SPI_Byte_Count}, 32'h00);
      cs_high();
      cs_low();
      send_byte(8'h4D, "post_reset_miso");
      cs_high();
      check_val("post_reset_word", {24'd0, Elite_7Seg_Disp_Word}, 32'h4D);
      check_val("post_reset_count", {24'd0, SPI_Byte_Count}, 32'h01);
      check_val("post_reset_strobes", strobes, 7);
      check_val("post_reset_frame_err", frame_errs, 2);

      // 256-byte burst wraps the counter
      Reset_SPI_Rx = 1'b1;
      wait_clk(2);
      Reset_SPI_Rx = 1'b0;
      exp_count = '0;
      last_byte = '0;
      wait_clk(10);
      cs_low();
      for (int i = 0; i < 256; i++)
         send_byte(8'(i), "wrap_miso");
      cs_high();
      check_val("wrap_strobes", strobes, 263);
      check_val("wrap_count", {24'd0, SPI_Byte_Count}, 32'h00);
      check_val("wrap_word", {24'd0, Elite_7Seg_Disp_Word}, 32'hFF);
      check_val("wrap_frame_err", frame_errs, 2);
      check_val("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
